// File: rtl/irq_arbiter.sv
// irq_arbiter: multi-source interrupt arbiter feeding the single IRQ input of
// the instruction decoder. Captures N_SRC interrupt lines into pending bits
// (sticky rising-edge capture, or level-following), masks them with a
// software enable register, and requests the lowest-index eligible source.
// Once the CPU takes the request, further requests are held off until eret.
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   reset     synchronous active-high reset
//   src       raw interrupt lines, synchronous to clk
//   en_we     enable register write strobe
//   en_wdata  new enable value, bit i enables source i
//   clr_we    software clear of one pending bit (edge mode only)
//   clr_id    index of the pending bit to clear
//   kernel    CPU in kernel mode; no request is raised while high
//   take      CPU accepted the interrupt this cycle
//   eret      handler finished
//   IRQ       registered interrupt request to the decoder
//   irq_id    index of the source being requested or serviced
//   pending   pending register
//   enable    enable register
//   busy      handler in progress
module irq_arbiter #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned ID_W  = 2,
  parameter int unsigned EDGE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic             en_we,
  input  logic [N_SRC-1:0] en_wdata,
  input  logic             clr_we,
  input  logic [ID_W-1:0]  clr_id,
  input  logic             kernel,
  input  logic             take,
  input  logic             eret,
  output logic             IRQ,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] enable,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] enable_q, enable_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr_mask;
  logic [N_SRC-1:0] elig;
  logic [ID_W-1:0]  winner;
  logic             take_now;

  assign elig     = pending_q & enable_q;
  assign take_now = (state_q == REQ) && take;

  // Pending capture; the rise term is OR-ed in after the clear so a set
  // and a clear landing on the same bit leave it set.
  always_comb begin
    rise     = src & ~src_q;
    clr_mask = '0;
    if (clr_we)
      clr_mask = clr_mask | (N_SRC'(1) << clr_id);
    if (take_now)
      clr_mask = clr_mask | (N_SRC'(1) << irq_id_q);
    if (EDGE != 0)
      pending_d = (pending_q & ~clr_mask) | rise;
    else
      pending_d = src;
  end

  always_comb begin
    enable_d = enable_q;
    if (en_we)
      enable_d = en_wdata;
  end

  // Lowest set index wins: scan from the top so the lowest hit is last.
  always_comb begin
    winner = '0;
    for (int unsigned i = N_SRC; i > 0; i--) begin
      if (elig[i-1])
        winner = ID_W'(i - 1);
    end
  end

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    unique case (state_q)
      IDLE: begin
        if ((elig != '0) && !kernel) begin
          state_d  = REQ;
          irq_id_d = winner;
        end
      end
      REQ: begin
        if (take) begin
          state_d = SERVICE;
        end else if ((elig == '0) || kernel) begin
          state_d = IDLE;
        end else begin
          irq_id_d = winner;
        end
      end
      SERVICE: begin
        if (eret)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      src_q     <= src;
      pending_q <= '0;
      enable_q  <= '0;
      irq_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      irq_id_q  <= irq_id_d;
    end
  end

  assign IRQ     = (state_q == REQ);
  assign busy    = (state_q == SERVICE);
  assign irq_id  = irq_id_q;
  assign pending = pending_q;
  assign enable  = enable_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed self-checking bench for irq_arbiter: one edge-mode instance and
// one level-mode instance sharing clock and reset.
module tb_irq_arbiter;

  logic       clk = 1'b0;
  logic       reset;

  logic [3:0] src, en_wdata;
  logic       en_we, clr_we, kernel, take, eret;
  logic [1:0] clr_id;
  logic       irq_o, busy_o;
  logic [1:0] id_o;
  logic [3:0] pend_o, en_o;

  logic [3:0] l_src, l_en_wdata;
  logic       l_en_we, l_clr_we, l_kernel, l_take, l_eret;
  logic [1:0] l_clr_id;
  logic       l_irq_o, l_busy_o;
  logic [1:0] l_id_o;
  logic [3:0] l_pend_o, l_en_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  irq_arbiter #(.N_SRC(4), .ID_W(2), .EDGE(1)) u_dut (
    .clk(clk), .reset(reset), .src(src), .en_we(en_we), .en_wdata(en_wdata),
    .clr_we(clr_we), .clr_id(clr_id), .kernel(kernel), .take(take),
    .eret(eret), .IRQ(irq_o), .irq_id(id_o), .pending(pend_o),
    .enable(en_o), .busy(busy_o)
  );

  irq_arbiter #(.N_SRC(4), .ID_W(2), .EDGE(0)) u_dut_lvl (
    .clk(clk), .reset(reset), .src(l_src), .en_we(l_en_we),
    .en_wdata(l_en_wdata), .clr_we(l_clr_we), .clr_id(l_clr_id),
    .kernel(l_kernel), .take(l_take), .eret(l_eret), .IRQ(l_irq_o),
    .irq_id(l_id_o), .pending(l_pend_o), .enable(l_en_o), .busy(l_busy_o)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one active edge, then settle before inputs change or get sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; src = '0; en_we = 0; en_wdata = '0; clr_we = 0; clr_id = '0;
    kernel = 0; take = 0; eret = 0;
    l_src = '0; l_en_we = 0; l_en_wdata = '0; l_clr_we = 0; l_clr_id = '0;
    l_kernel = 0; l_take = 0; l_eret = 0;
    tick(); tick();
    check("rst_irq", irq_o, 0);
    check("rst_id", id_o, 0);
    check("rst_pend", pend_o, 0);
    check("rst_en", en_o, 0);
    check("rst_busy", busy_o, 0);
    reset = 1'b0;

    // Basic request / take / eret
    en_we = 1; en_wdata = 4'hF; tick(); en_we = 0;
    check("en_write", en_o, 4'hF);
    src = 4'b0100; tick(); src = '0;
    check("b_pend", pend_o, 4'b0100);
    check("b_irq_early", irq_o, 0);
    tick();
    check("b_irq", irq_o, 1);
    check("b_id", id_o, 2);
    take = 1; tick(); take = 0;
    check("b_take_irq", irq_o, 0);
    check("b_take_busy", busy_o, 1);
    check("b_take_pend", pend_o, 0);
    eret = 1; tick(); eret = 0;
    check("b_eret_busy", busy_o, 0);
    check("b_eret_irq", irq_o, 0);
    tick();
    check("b_idle_irq", irq_o, 0);

    // Priority and preemption
    src = 4'b1000; tick(); src = '0;
    tick();
    check("p_irq", irq_o, 1);
    check("p_id3", id_o, 3);
    src = 4'b0010; tick(); src = '0;
    tick();
    check("p_irq_pre", irq_o, 1);
    check("p_id1", id_o, 1);
    take = 1; tick(); take = 0;
    check("p_pend", pend_o, 4'b1000);
    check("p_busy", busy_o, 1);
    check("p_svc_id", id_o, 1);
    eret = 1; tick(); eret = 0;
    check("p_eret_irq", irq_o, 0);
    tick();
    check("p_reassert", irq_o, 1);
    check("p_reassert_id", id_o, 3);
    take = 1; tick(); take = 0;
    eret = 1; tick(); eret = 0;

    // Masking and withdrawal
    en_we = 1; en_wdata = 4'b0001; tick(); en_we = 0;
    src = 4'b0100; tick(); src = '0;
    check("m_pend", pend_o, 4'b0100);
    tick();
    check("m_masked", irq_o, 0);
    en_we = 1; en_wdata = 4'b0100; tick(); en_we = 0;
    check("m_en_1", irq_o, 0);
    tick();
    check("m_en_2", irq_o, 1);
    check("m_en_id", id_o, 2);
    en_we = 1; en_wdata = '0; tick(); en_we = 0;
    tick();
    check("m_withdraw", irq_o, 0);
    check("m_pend_kept", pend_o, 4'b0100);
    clr_we = 1; clr_id = 2; tick(); clr_we = 0;
    check("m_swclr", pend_o, 0);

    // Kernel blocking
    en_we = 1; en_wdata = 4'hF; tick(); en_we = 0;
    kernel = 1; src = 4'b0001; tick(); src = '0;
    check("k_pend", pend_o, 4'b0001);
    tick(); tick();
    check("k_blocked", irq_o, 0);
    kernel = 0; tick();
    check("k_irq", irq_o, 1);
    check("k_id", id_o, 0);
    take = 1; tick(); take = 0;
    check("k_take_pend", pend_o, 0);
    eret = 1; tick(); eret = 0;

    // Set beats clear on the same bit
    kernel = 1; src = 4'b0001; clr_we = 1; clr_id = 0; tick();
    src = '0; clr_we = 0;
    check("c_set_wins", pend_o, 4'b0001);
    clr_we = 1; tick(); clr_we = 0;
    check("c_clr", pend_o, 0);
    kernel = 0;

    // Reset mid-service, with src[0] held high across reset release
    src = 4'b0100; tick(); src = '0;
    tick();
    take = 1; tick(); take = 0;
    check("r_busy", busy_o, 1);
    reset = 1; src = 4'b0001; tick();
    check("r_irq", irq_o, 0);
    check("r_busy0", busy_o, 0);
    check("r_en", en_o, 0);
    check("r_pend", pend_o, 0);
    check("r_id", id_o, 0);
    tick(); reset = 0; tick();
    check("r_no_edge", pend_o, 0);
    en_we = 1; en_wdata = 4'hF; tick(); en_we = 0;
    tick();
    check("r_no_irq", irq_o, 0);
    src = '0;

    // Level mode
    l_en_we = 1; l_en_wdata = 4'hF; tick(); l_en_we = 0;
    l_src = 4'b0010; tick();
    check("l_pend", l_pend_o, 4'b0010);
    l_clr_we = 1; l_clr_id = 1; tick(); l_clr_we = 0;
    check("l_clr_ignored", l_pend_o, 4'b0010);
    check("l_irq", l_irq_o, 1);
    check("l_id", l_id_o, 1);
    l_take = 1; tick(); l_take = 0;
    check("l_busy", l_busy_o, 1);
    check("l_take_pend", l_pend_o, 4'b0010);
    l_eret = 1; tick(); l_eret = 0;
    check("l_eret", l_busy_o, 0);
    tick();
    check("l_rereq", l_irq_o, 1);
    check("l_rereq_id", l_id_o, 1);
    l_src = '0; tick(); tick();
    check("l_drop_irq", l_irq_o, 0);
    check("l_drop_pend", l_pend_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
